// File: rtl/adc_spi_sequencer_if.sv
// Captured-sample channel from the ADC SPI sequencer to the ANC filter datapath.
// A sample transfers on any clock edge where valid and ready are both high.
interface adc_spi_sequencer_if;
  logic [10:0] sample;
  logic        valid;
  logic        ready;

  modport master (
    output sample,
    output valid,
    input  ready
  );

  modport slave (
    input  sample,
    input  valid,
    output ready
  );
endinterface

// File: rtl/adc_spi_sequencer.sv
// Sequences one 16-bit SPI frame per sample period for the ANC ADC receiver slave.
// Optional feature: define ADC_OVERRUN_DET_EN to report unconsumed-sample overwrites on o_overrun.
//
// state        | meaning
// ST_IDLE      | SPI pins idle, waiting for a period tick
// ST_ASSERT_SS | SS_n low for one cycle before the first SCK rise
// ST_SHIFT     | 16 SCK pulses, CLK_DIV cycles high then CLK_DIV cycles low
// ST_CAPTURE   | 3 cycles: flag synchroniser settles, sample captured
// ST_CLEAR     | SpiReset high for CLK_DIV cycles to re-arm the slave
module adc_spi_sequencer #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  output logic                       o_sck,
  output logic                       o_ss_n,
  output logic                       o_spi_reset,
  input  logic [10:0]                i_spi_data,
  input  logic                       i_spi_flag,
  output logic                       o_busy,
  output logic                       o_overrun,
  adc_spi_sequencer_if.master        io_sample
);

  localparam int              TMR_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]      DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0]      CAP_LOAD = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT_SS,
    ST_SHIFT,
    ST_CAPTURE,
    ST_CLEAR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic             w_tick;
  logic [7:0]       r_div;
  logic [7:0]       w_div_nxt;
  logic [4:0]       r_pulse;
  logic [4:0]       w_pulse_nxt;
  logic             r_sck;
  logic             w_sck_nxt;
  logic             r_ss_n;
  logic             w_ss_n_nxt;
  logic             r_spi_reset;
  logic             w_spi_reset_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_capture;
  logic             w_accept;
  logic [1:0]       r_flag_sync;
  logic             w_flag_unused;
  logic [10:0]      r_sample;
  logic             r_valid;

  // Period timer: down-counter, tick on terminal count while enabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmr <= '0;
    end else if (!i_enable) begin
      r_tmr <= '0;
    end else if (r_tmr == '0) begin
      r_tmr <= TMR_LOAD;
    end else begin
      r_tmr <= r_tmr - TMR_W'(1);
    end
  end

  assign w_tick = i_enable && (r_tmr == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_pulse     <= '0;
      r_sck       <= 1'b0;
      r_ss_n      <= 1'b1;
      r_spi_reset <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_pulse     <= w_pulse_nxt;
      r_sck       <= w_sck_nxt;
      r_ss_n      <= w_ss_n_nxt;
      r_spi_reset <= w_spi_reset_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // r_div is reused as half-period, capture and clear timer; all outputs are next-state registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div;
    w_pulse_nxt     = r_pulse;
    w_sck_nxt       = r_sck;
    w_ss_n_nxt      = r_ss_n;
    w_spi_reset_nxt = r_spi_reset;
    w_busy_nxt      = r_busy;
    w_capture       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_sck_nxt       = 1'b0;
        w_ss_n_nxt      = 1'b1;
        w_spi_reset_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        if (w_tick) begin
          w_state_nxt = ST_ASSERT_SS;
          w_ss_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_ASSERT_SS: begin
        w_state_nxt = ST_SHIFT;
        w_sck_nxt   = 1'b1;
        w_div_nxt   = DIV_LOAD;
        w_pulse_nxt = 5'd1;
      end
      ST_SHIFT: begin
        if (r_div != 8'd0) begin
          w_div_nxt = r_div - 8'd1;
        end else begin
          w_div_nxt = DIV_LOAD;
          if (r_sck) begin
            w_sck_nxt = 1'b0;
          end else if (r_pulse == 5'd16) begin
            w_state_nxt = ST_CAPTURE;
            w_div_nxt   = CAP_LOAD;
          end else begin
            w_sck_nxt   = 1'b1;
            w_pulse_nxt = r_pulse + 5'd1;
          end
        end
      end
      ST_CAPTURE: begin
        if (r_div == 8'd0) begin
          w_state_nxt     = ST_CLEAR;
          w_ss_n_nxt      = 1'b1;
          w_spi_reset_nxt = 1'b1;
          w_div_nxt       = DIV_LOAD;
        end else begin
          w_div_nxt = r_div - 8'd1;
          w_capture = (r_div == 8'd1);
        end
      end
      ST_CLEAR: begin
        if (r_div == 8'd0) begin
          w_state_nxt     = ST_IDLE;
          w_spi_reset_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The receiver flag is informational only; it is synchronised but never gates the capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flag_sync <= 2'b00;
    end else begin
      r_flag_sync <= {r_flag_sync[0], i_spi_flag};
    end
  end

  assign w_flag_unused = r_flag_sync[1];

  assign w_accept = r_valid && io_sample.ready;

  // A capture coinciding with acceptance keeps valid high with the new sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else if (w_capture) begin
      r_sample <= i_spi_data;
      r_valid  <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

`ifdef ADC_OVERRUN_DET_EN
  logic r_overrun;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (w_capture && r_valid && !io_sample.ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 1'b0;
`endif

  assign o_sck           = r_sck;
  assign o_ss_n          = r_ss_n;
  assign o_spi_reset     = r_spi_reset;
  assign o_busy          = r_busy;
  assign io_sample.sample = r_sample;
  assign io_sample.valid  = r_valid;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Directed bench for adc_spi_sequencer with CLK_DIV=2, SAMPLE_PERIOD=100 and a combined ADC/receiver model.
// The receiver model turns the 16-bit SDI word w into {~w[9], w[8:0], 1'b0}.
module tb_adc_spi_sequencer;
  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 100;
`ifdef ADC_OVERRUN_DET_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        enable = 1'b0;
  logic        sck;
  logic        ss_n;
  logic        spi_reset;
  logic        busy;
  logic        overrun;
  logic [10:0] spi_data = '0;
  logic        spi_flag = 1'b0;
  logic [15:0] adc_word = 16'h0155;

  adc_spi_sequencer_if sif ();

  adc_spi_sequencer #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_enable   (enable),
    .o_sck      (sck),
    .o_ss_n     (ss_n),
    .o_spi_reset(spi_reset),
    .i_spi_data (spi_data),
    .i_spi_flag (spi_flag),
    .o_busy     (busy),
    .o_overrun  (overrun),
    .io_sample  (sif)
  );

  always #5 clk = ~clk;

  // ADC + receiver slave: shifts on SCK falling edge, cleared while SpiReset is high.
  int         bitcnt = 0;
  logic [9:0] shreg  = '0;
  always @(negedge sck or posedge spi_reset) begin
    if (spi_reset) begin
      bitcnt   = 0;
      spi_flag = 1'b0;
    end else if (bitcnt < 16) begin
      shreg  = {shreg[8:0], adc_word[4'(15 - bitcnt)]};
      bitcnt = bitcnt + 1;
      if (bitcnt == 16) begin
        spi_data = {~shreg[9], shreg[8:0], 1'b0};
        spi_flag = 1'b1;
      end
    end
  end

  // Event monitor, sampled on the falling clock edge.
  int cyc = 0, ss_cnt = 0, ss_cyc = 0, valid_cnt = 0, valid_cyc = 0, done_cnt = 0;
  int sck_total = 0, frame_rises = 0, last_rise = 0, first_rise_cyc = 0;
  int per_min = 0, per_max = 0, busy_w = 0, rst_w = 0, last_rst_w = 0;
  logic ss_q = 1'b1, sck_q = 1'b0, valid_q = 1'b0, busy_q = 1'b0, spirst_q = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!ss_n && ss_q) begin
      ss_cnt      = ss_cnt + 1;
      ss_cyc      = cyc;
      frame_rises = 0;
      per_min     = 1000;
      per_max     = 0;
      busy_w      = 0;
    end
    if (sck && !sck_q) begin
      if (frame_rises > 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end else begin
        first_rise_cyc = cyc;
      end
      frame_rises = frame_rises + 1;
      sck_total   = sck_total + 1;
      last_rise   = cyc;
    end
    if (sif.valid && !valid_q) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (busy) busy_w = busy_w + 1;
    if (!busy && busy_q) done_cnt = done_cnt + 1;
    if (spi_reset) begin
      rst_w = rst_w + 1;
    end else begin
      if (spirst_q) last_rst_w = rst_w;
      rst_w = 0;
    end
    ss_q     = ss_n;
    sck_q    = sck;
    valid_q  = sif.valid;
    busy_q   = busy;
    spirst_q = spi_reset;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
    n_checks = n_checks + 1;
    assert (obsv === expv) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obsv, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ss(input string tag);
    int target = ss_cnt + 1;
    int g = 0;
    while (ss_cnt < target && g < 300) begin
      tick(1);
      g++;
    end
    chk(tag, 32'(ss_cnt >= target), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int target = valid_cnt + 1;
    int g = 0;
    while (valid_cnt < target && g < 300) begin
      tick(1);
      g++;
    end
    chk(tag, 32'(valid_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int target = done_cnt + 1;
    int g = 0;
    while (done_cnt < target && g < 300) begin
      tick(1);
      g++;
    end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc0, s1, s3, ss_before, sck_before;
    sif.ready = 1'b0;

    // Reset values while reset is held
    tick(3);
    chk("rst_sck", sck, 0);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_spi_reset", spi_reset, 1);
    chk("rst_sample", sif.sample, 0);
    chk("rst_valid", sif.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    rst = 1'b0;
    #1;
    chk("spi_reset_held_until_edge", spi_reset, 1);
    tick(1);
    chk("spi_reset_first_edge", spi_reset, 0);
    chk("idle_sck", sck, 0);
    chk("idle_ss_n", ss_n, 1);

    tick(500);
    chk("no_frames_disabled", ss_cnt, 0);
    chk("no_sck_disabled", sck_total, 0);

    // Frame 1: word 0155 -> 6AA, consumer ready
    sif.ready = 1'b1;
    enable    = 1'b1;
    cyc0      = cyc;
    wait_ss("f1_ss_seen");
    s1 = ss_cyc;
    chk("f1_tick_to_ss", s1 - cyc0, 1);
    chk("f1_busy", busy, 1);
    wait_valid("f1_valid_seen");
    chk("f1_ss_to_valid", valid_cyc - s1, 67);
    chk("f1_ss_to_first_sck", first_rise_cyc - s1, 1);
    chk("f1_sample", sif.sample, 11'h6AA);
    tick(1);
    chk("f1_accepted", sif.valid, 0);
    wait_done("f1_done_seen");
    chk("f1_sck_pulses", frame_rises, 16);
    chk("f1_sck_per_min", per_min, 4);
    chk("f1_sck_per_max", per_max, 4);
    chk("f1_spi_reset_width", last_rst_w, 2);
    chk("f1_busy_width", busy_w, 70);

    // Frame 2: word 03F0 -> 3E0, left unconsumed
    adc_word  = 16'h03F0;
    sif.ready = 1'b0;
    wait_ss("f2_ss_seen");
    chk("f2_period", ss_cyc - s1, 100);
    wait_done("f2_done_seen");
    chk("f2_sample", sif.sample, 11'h3E0);
    chk("f2_valid", sif.valid, 1);

    // Frame 3: word 0201 -> 002, ready only on the capture cycle
    adc_word = 16'h0201;
    wait_ss("f3_ss_seen");
    s3 = ss_cyc;
    tick(66);
    sif.ready = 1'b1;
    tick(1);
    sif.ready = 1'b0;
    chk("f3_capture_vs_accept_valid", sif.valid, 1);
    chk("f3_capture_vs_accept_sample", sif.sample, 11'h002);
    chk("f3_no_overrun", overrun, 0);
    chk("f3_capture_cycle", cyc - s3, 67);
    wait_done("f3_done_seen");

    // Frame 4: word 0000 -> 400 overwrites unconsumed frame-3 sample
    adc_word = 16'h0000;
    wait_ss("f4_ss_seen");
    wait_done("f4_done_seen");
    chk("f4_sample", sif.sample, 11'h400);
    chk("f4_valid", sif.valid, 1);
    chk("f4_overrun", overrun, EXP_OVR);
    sif.ready = 1'b1;
    tick(2);
    chk("f4_valid_cleared", sif.valid, 0);
    chk("f4_overrun_sticky", overrun, EXP_OVR);

    // Frame 5: Enable dropped mid-SHIFT, frame completes, nothing further
    adc_word = 16'h03F0;
    wait_ss("f5_ss_seen");
    tick(10);
    enable = 1'b0;
    wait_done("f5_done_seen");
    chk("f5_sck_pulses", frame_rises, 16);
    chk("f5_spi_reset_width", last_rst_w, 2);
    chk("f5_sample", sif.sample, 11'h3E0);
    ss_before  = ss_cnt;
    sck_before = sck_total;
    tick(250);
    chk("f5_no_new_ss", ss_cnt, ss_before);
    chk("f5_no_new_sck", sck_total, sck_before);

    // Reset pulsed mid-SHIFT while SCK is high
    adc_word = 16'h0155;
    enable   = 1'b1;
    wait_ss("f6_ss_seen");
    tick(18);
    chk("f6_sck_high_before_reset", sck, 1);
    rst = 1'b1;
    #1;
    chk("f6_async_sck", sck, 0);
    chk("f6_async_ss_n", ss_n, 1);
    chk("f6_async_spi_reset", spi_reset, 1);
    chk("f6_async_busy", busy, 0);
    enable = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);

    // Frame 7: slave realigned, word 0201 -> 002
    adc_word = 16'h0201;
    enable   = 1'b1;
    wait_ss("f7_ss_seen");
    wait_valid("f7_valid_seen");
    chk("f7_sample", sif.sample, 11'h002);
    chk("f7_overrun_cleared", overrun, 0);
    wait_done("f7_done_seen");
    chk("f7_sck_pulses", frame_rises, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
